// File: rtl/serial_sub_if.sv
// serial_sub_if: operand/result bundle for the bit-serial subtractor.
// master drives the request, slave returns the framed result.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  d, bout, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output d, bout, busy, done
  );
endinterface

// File: rtl/serial_sub.sv
// serial_sub: bit-serial d = a - b - bin, LSB first, one bit per clock.
// Borrow flop carries between bits; start/busy/done frames each op.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  serial_sub_if.slave io
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] rd_nx;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             br;
  logic             br_nx;
  logic [CW-1:0]    cnt;
  logic             a0;
  logic             b0;
  logic             dbit;
  logic             last;
  logic             load;
  logic             step;

  // One full-subtractor slice on the current LSBs plus the borrow flop.
  always_comb begin
    a0    = ra[0];
    b0    = rb[0];
    dbit  = a0 ^ b0 ^ br;
    br_nx = (~a0 & b0) | (~(a0 ^ b0) & br);
    rd_nx = {dbit, rd[WIDTH-1:1]};
    last  = (cnt == CW'(WIDTH - 1));
  end

  // Next-state and datapath enables; start only counts in IDLE/FIN.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state)
      IDLE: begin
        if (io.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_nx = FIN;
        end
      end
      FIN: begin
        if (io.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight op without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Operand shifters, borrow flop, bit counter and result shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra  <= '0;
      rb  <= '0;
      rd  <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      ra  <= io.a;
      rb  <= io.b;
      br  <= io.bin;
      cnt <= '0;
    end else if (step) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      rd  <= rd_nx;
      br  <= br_nx;
      cnt <= cnt + CW'(1);
    end
  end

  // Result holds from the completion edge until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= '0;
      bout_q <= 1'b0;
    end else if (step && last) begin
      d_q    <= rd_nx;
      bout_q <= br_nx;
    end
  end

  assign io.d    = d_q;
  assign io.bout = bout_q;
  assign io.busy = (state == RUN);
  assign io.done = (state == FIN);
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed + random checks of serial_sub
// against an integer a - b - bin reference.
module tb_serial_sub;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ndone = 0;

  serial_sub_if #(.WIDTH(W)) io ();

  serial_sub #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (io.done === 1'b1) ndone++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] ref_sub(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic bin);
    int diff;
    logic [W-1:0] lo;
    diff = int'(a) - int'(b) - int'(bin);
    lo = W'(diff);
    return {diff < 0, lo};
  endfunction

  // One operation; glitch >= 0 pulses start (with junk operands)
  // during RUN at that cycle offset, which must be ignored.
  task automatic do_op(input string tag,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic bin,
                       input int glitch);
    logic [W:0] exp;
    int lat;
    int busyc;
    int n0;
    exp = ref_sub(a, b, bin);
    n0 = ndone;
    io.a = a;
    io.b = b;
    io.bin = bin;
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    io.a = W'($urandom);
    io.b = W'($urandom);
    io.bin = 1'($urandom);
    lat = 0;
    busyc = 0;
    while (io.done !== 1'b1 && lat < 40) begin
      if (io.busy === 1'b1) busyc++;
      io.start = (lat == glitch);
      if (lat == glitch) begin
        io.a = '0;
        io.b = '1;
      end
      tick();
      lat++;
    end
    io.start = 1'b0;
    chk({tag, ":lat"}, lat, W);
    chk({tag, ":busy"}, busyc, W);
    chk({tag, ":d"}, io.d, exp[W-1:0]);
    chk({tag, ":bout"}, io.bout, exp[W]);
    tick();
    chk({tag, ":ndone"}, ndone, n0 + 1);
    chk({tag, ":done_lo"}, io.done, 0);
  endtask

  logic [W-1:0] ba [5];
  logic [W-1:0] bb [5];
  logic         bc [5];
  logic [W:0]   e;
  logic [W-1:0] prev_d;
  int           lat;
  int           stable;
  int           n0;

  initial begin
    io.start = 1'b0;
    io.a = '0;
    io.b = '0;
    io.bin = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst:d", io.d, 0);
    chk("rst:bout", io.bout, 0);
    chk("rst:busy", io.busy, 0);
    chk("rst:done", io.done, 0);
    rst = 1'b0;
    tick();

    do_op("5a-23", 8'h5a, 8'h23, 1'b0, -1);
    do_op("10-20", 8'h10, 8'h20, 1'b0, -1);
    do_op("00-00-1", 8'h00, 8'h00, 1'b1, -1);
    do_op("ff-ff", 8'hff, 8'hff, 1'b0, -1);
    do_op("glitch", 8'h80, 8'h01, 1'b0, 3);
    chk("glitch:d7f", io.d, 8'h7f);

    // Back-to-back with start held high.
    for (int k = 0; k < 5; k++) begin
      ba[k] = W'($urandom);
      bb[k] = W'($urandom);
      bc[k] = 1'($urandom);
    end
    io.a = ba[0];
    io.b = bb[0];
    io.bin = bc[0];
    io.start = 1'b1;
    prev_d = io.d;
    tick();
    for (int k = 0; k < 5; k++) begin
      lat = 0;
      stable = 1;
      while (io.done !== 1'b1 && lat < 40) begin
        if (io.d !== prev_d) stable = 0;
        tick();
        lat++;
      end
      e = ref_sub(ba[k], bb[k], bc[k]);
      chk($sformatf("b2b%0d:lat", k), lat, W);
      chk($sformatf("b2b%0d:stable", k), stable, 1);
      chk($sformatf("b2b%0d:d", k), io.d, e[W-1:0]);
      chk($sformatf("b2b%0d:bout", k), io.bout, e[W]);
      prev_d = io.d;
      if (k < 4) begin
        io.a = ba[k+1];
        io.b = bb[k+1];
        io.bin = bc[k+1];
      end else begin
        io.start = 1'b0;
      end
      tick();
    end
    chk("b2b:busy_end", io.busy, 0);
    chk("b2b:d_hold", io.d, prev_d);

    // Reset during the 4th RUN cycle.
    io.a = 8'h55;
    io.b = 8'h11;
    io.bin = 1'b0;
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    tick();
    tick();
    tick();
    n0 = ndone;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst:d", io.d, 0);
    chk("mrst:bout", io.bout, 0);
    chk("mrst:busy", io.busy, 0);
    chk("mrst:done", io.done, 0);
    repeat (12) tick();
    chk("mrst:nodone", ndone, n0);
    do_op("03-01", 8'h03, 8'h01, 1'b0, -1);

    // Random operations.
    for (int i = 0; i < 1000; i++) begin
      int g;
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 2)) : -1;
      do_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom),
            1'($urandom), g);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
